// File: rtl/fccc_lock_sequencer.sv
// fccc_lock_sequencer: brings up fabric and SCCB/APB peripheral resets
// once the PLL lock has been stable for a full window. Any later loss of
// lock forces every reset back on and bumps a saturating loss counter.
module fccc_lock_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int STAGE_DELAY        = 4,
  parameter int SW_RST_CYCLES      = 8,
  parameter int CNT_W              = 4
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             LOCK,
  input  logic             SOFT_RST_REQ,
  output logic             FAB_RESET_N,
  output logic             PERIPH_RESET_N,
  output logic             READY,
  output logic [CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [2:0]       STATE
);

  // The delay counter only ever has to reach the largest terminal value
  // minus one, so sizing it on the largest delay keeps it from wrapping.
  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int MAX_CYC = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
  localparam int CTR_W   = $clog2(MAX_CYC);

  localparam logic [CTR_W-1:0] STAB_LAST  = CTR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] STAGE_LAST = CTR_W'(STAGE_DELAY - 1);
  localparam logic [CTR_W-1:0] SW_LAST    = CTR_W'(SW_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABILIZE  = 3'd1,
    REL_FAB    = 3'd2,
    REL_PERIPH = 3'd3,
    RUN        = 3'd4,
    SW_RESET   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               sync1_q, sync1_d;
  logic               lock_s_q, lock_s_d;
  logic               fab_reset_n_q, fab_reset_n_d;
  logic               periph_reset_n_q, periph_reset_n_d;
  logic               ready_q, ready_d;
  logic               lock_lost;

  // Next-state, delay counter, loss counter and registered output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_cnt_d = loss_cnt_q;
    sync1_d    = LOCK;
    lock_s_d   = sync1_q;
    lock_lost  = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STAB_LAST) begin
          state_d = REL_FAB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_FAB: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_PERIPH: begin
        if (cnt_q == STAGE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (SOFT_RST_REQ) begin
          state_d = SW_RESET;
          cnt_d   = '0;
        end
      end
      SW_RESET: begin
        if (cnt_q == SW_LAST) begin
          state_d = REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Losing lock after the first release wins over everything else.
    if (!lock_s_q && (state_q == REL_FAB || state_q == REL_PERIPH ||
                      state_q == RUN || state_q == SW_RESET)) begin
      lock_lost = 1'b1;
    end
    if (lock_lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      if (loss_cnt_q != {CNT_W{1'b1}}) begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end

    fab_reset_n_d    = (state_d == REL_FAB) || (state_d == REL_PERIPH) ||
                       (state_d == RUN) || (state_d == SW_RESET);
    periph_reset_n_d = (state_d == REL_PERIPH) || (state_d == RUN);
    ready_d          = (state_d == RUN);
  end

  // State, counters, synchronizer and output registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      loss_cnt_q       <= '0;
      sync1_q          <= 1'b0;
      lock_s_q         <= 1'b0;
      fab_reset_n_q    <= 1'b0;
      periph_reset_n_q <= 1'b0;
      ready_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      loss_cnt_q       <= loss_cnt_d;
      sync1_q          <= sync1_d;
      lock_s_q         <= lock_s_d;
      fab_reset_n_q    <= fab_reset_n_d;
      periph_reset_n_q <= periph_reset_n_d;
      ready_q          <= ready_d;
    end
  end

  assign FAB_RESET_N    = fab_reset_n_q;
  assign PERIPH_RESET_N = periph_reset_n_q;
  assign READY          = ready_q;
  assign LOCK_LOSS_CNT  = loss_cnt_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_fccc_lock_sequencer.sv
// Directed bench for fccc_lock_sequencer; expected output vectors are
// queued as each step is driven and popped when the outputs are sampled.
module tb_fccc_lock_sequencer;

  logic       PCLK;
  logic       PRESETN;
  logic       LOCK;
  logic       SOFT_RST_REQ;
  logic       FAB_RESET_N;
  logic       PERIPH_RESET_N;
  logic       READY;
  logic [3:0] LOCK_LOSS_CNT;
  logic [2:0] STATE;

  typedef struct {
    string      tag;
    logic [9:0] vec;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   lossModel = 0;

  fccc_lock_sequencer dut (
    .PCLK           (PCLK),
    .PRESETN        (PRESETN),
    .LOCK           (LOCK),
    .SOFT_RST_REQ   (SOFT_RST_REQ),
    .FAB_RESET_N    (FAB_RESET_N),
    .PERIPH_RESET_N (PERIPH_RESET_N),
    .READY          (READY),
    .LOCK_LOSS_CNT  (LOCK_LOSS_CNT),
    .STATE          (STATE)
  );

  // 10-unit clock period
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pop the oldest expectation and compare against the live outputs
  task automatic checkOutput();
    exp_t       e;
    logic [9:0] obs;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e   = expQ.pop_front();
    obs = {FAB_RESET_N, PERIPH_RESET_N, READY, LOCK_LOSS_CNT, STATE};
    checks++;
    assert (obs === e.vec) else begin
      errors++;
      $error("[TB] FAIL %s observed fab/per/rdy/cnt/st=%b/%b/%b/%0d/%0d expected=%b/%b/%b/%0d/%0d",
             e.tag, obs[9], obs[8], obs[7], obs[6:3], obs[2:0],
             e.vec[9], e.vec[8], e.vec[7], e.vec[6:3], e.vec[2:0]);
    end
  endtask

  // Drive inputs, queue the expectation, advance, then sample and check.
  // edges==0 samples 1 time unit later without waiting for a clock.
  task automatic applyStimulus(input logic rstnV, input logic lockV, input logic softV,
                               input int edges, input string tag,
                               input logic fab, input logic per, input logic rdy,
                               input int cnt, input logic [2:0] st);
    exp_t e;
    PRESETN      = rstnV;
    LOCK         = lockV;
    SOFT_RST_REQ = softV;
    e.tag = tag;
    e.vec = {fab, per, rdy, 4'(cnt), st};
    expQ.push_back(e);
    if (edges == 0) begin
      #1;
    end else begin
      repeat (edges) @(posedge PCLK);
      @(negedge PCLK);
    end
    checkOutput();
  endtask

  // Full bring-up from WAIT_LOCK, LOCK rising at the first call (edge n next)
  task automatic runSequence(input string pfx);
    applyStimulus(1, 1, 0, 18, {pfx, "_stab_n17"},   0, 0, 0, lossModel, 3'd1);
    applyStimulus(1, 1, 0, 1,  {pfx, "_relfab_n18"}, 1, 0, 0, lossModel, 3'd2);
    applyStimulus(1, 1, 0, 3,  {pfx, "_relfab_n21"}, 1, 0, 0, lossModel, 3'd2);
    applyStimulus(1, 1, 0, 1,  {pfx, "_relper_n22"}, 1, 1, 0, lossModel, 3'd3);
    applyStimulus(1, 1, 0, 3,  {pfx, "_relper_n25"}, 1, 1, 0, lossModel, 3'd3);
    applyStimulus(1, 1, 0, 1,  {pfx, "_run_n26"},    1, 1, 1, lossModel, 3'd4);
  endtask

  // Drop LOCK while in RUN; resets come back on two synchronizer edges later
  task automatic lossStep(input string pfx);
    applyStimulus(1, 0, 0, 2, {pfx, "_loss_a1"}, 1, 1, 1, lossModel, 3'd4);
    if (lossModel < 15) lossModel++;
    applyStimulus(1, 0, 0, 1, {pfx, "_loss_a2"}, 0, 0, 0, lossModel, 3'd0);
  endtask

  initial begin
    PRESETN      = 1'b0;
    LOCK         = 1'b0;
    SOFT_RST_REQ = 1'b0;
    @(negedge PCLK);

    // Power-up: reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, "powerup_rst", 0, 0, 0, 0, 3'd0);
    end
    applyStimulus(1, 0, 0, 2, "powerup_idle", 0, 0, 0, 0, 3'd0);

    // Normal lock
    runSequence("normal");

    // Lock loss in RUN
    lossStep("loss1");

    // Unstable lock: 10 cycles high, 3 low, then high for good
    applyStimulus(1, 1, 0, 10, "unstable_pulse", 0, 0, 0, lossModel, 3'd1);
    applyStimulus(1, 0, 0, 3,  "unstable_drop",  0, 0, 0, lossModel, 3'd0);
    runSequence("unstable");

    // Soft reset: one-cycle request in RUN
    applyStimulus(1, 1, 1, 1, "soft_enter", 1, 0, 0, lossModel, 3'd5);
    applyStimulus(1, 1, 0, 7, "soft_hold",  1, 0, 0, lossModel, 3'd5);
    applyStimulus(1, 1, 0, 1, "soft_relper",1, 1, 0, lossModel, 3'd3);
    applyStimulus(1, 1, 0, 3, "soft_wait",  1, 1, 0, lossModel, 3'd3);
    applyStimulus(1, 1, 0, 1, "soft_ready", 1, 1, 1, lossModel, 3'd4);

    // Soft request on the same cycle lock_s falls: loss wins
    applyStimulus(1, 0, 0, 2, "simul_pre", 1, 1, 1, lossModel, 3'd4);
    if (lossModel < 15) lossModel++;
    applyStimulus(1, 0, 1, 1, "simul_loss", 0, 0, 0, lossModel, 3'd0);
    applyStimulus(1, 0, 0, 1, "simul_idle", 0, 0, 0, lossModel, 3'd0);

    // PRESETN pulsed during REL_PERIPH
    applyStimulus(1, 1, 0, 23, "prst_relper", 1, 1, 0, lossModel, 3'd3);
    lossModel = 0;
    applyStimulus(0, 1, 0, 0, "prst_async", 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 1, 0, 2, "prst_hold",  0, 0, 0, 0, 3'd0);
    runSequence("prst_reseq");

    // Repeated losses saturate the counter
    for (int k = 0; k < 20; k++) begin
      lossStep("sat");
      if (k < 19) runSequence("sat");
    end
    applyStimulus(1, 0, 0, 1, "sat_final", 0, 0, 0, 15, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fccc_lock_sequencer.md
Name: fccc_lock_sequencer

Overview:
- Controller for the fabric clock conditioning block (GL0/LOCK pair) feeding the SCCB APB subsystem.
- Clocked by GL0. Monitors the PLL LOCK output and requires it to stay high for a stable window.
- Releases fabric and SCCB peripheral resets in stages, then asserts READY.
- On lock loss it re-asserts all resets and counts the event; it also provides a software-requested peripheral reset.

Parameters:
LOCK_STABLE_CYCLES, 16, consecutive synchronized-LOCK-high cycles required before the first release (>=2)
STAGE_DELAY, 4, cycles between each staged release (>=1)
SW_RST_CYCLES, 8, peripheral reset hold time for a software request (>=1)
CNT_W, 4, width of the lock-loss event counter

Ports:
PCLK  in  1  fabric clock (GL0)
PRESETN  in  1  asynchronous active-low reset
LOCK  in  1  PLL lock, asynchronous to PCLK
SOFT_RST_REQ  in  1  synchronous level request for a peripheral reset
FAB_RESET_N  out  1  active-low fabric reset
PERIPH_RESET_N  out  1  active-low SCCB/APB peripheral reset
READY  out  1  sequence complete, clocks stable
LOCK_LOSS_CNT  out  CNT_W  saturating count of lock losses after the first release
STATE  out  3  current state encoding, for debug

Behaviour:
- Interface: one clock PCLK; reset PRESETN is asynchronous and active-low.
- Reset values while PRESETN=0: state WAIT_LOCK, FAB_RESET_N=0, PERIPH_RESET_N=0, READY=0, LOCK_LOSS_CNT=0, internal counter=0, synchronizer flops=0.
- LOCK passes through a 2-flop synchronizer; lock_s is the second flop's output. All decisions use lock_s only.
- Outputs are registered and decoded from the state register, so they change on the same edge as the state.
- State encoding: WAIT_LOCK=0, STABILIZE=1, REL_FAB=2, REL_PERIPH=3, RUN=4, SW_RESET=5.
- Output decode by state:
  - FAB_RESET_N=1 in REL_FAB, REL_PERIPH, RUN, SW_RESET.
  - PERIPH_RESET_N=1 in REL_PERIPH, RUN.
  - READY=1 in RUN only.
- WAIT_LOCK: if lock_s=1, go to STABILIZE and clear the counter.
- STABILIZE: the counter increments each cycle while lock_s=1.
  - If lock_s=0, return to WAIT_LOCK. No loss is counted.
  - When counter==LOCK_STABLE_CYCLES-1 and lock_s=1, go to REL_FAB and clear the counter.
- REL_FAB: count STAGE_DELAY cycles, then go to REL_PERIPH and clear the counter.
- REL_PERIPH: count STAGE_DELAY cycles, then go to RUN.
- RUN: if SOFT_RST_REQ=1, go to SW_RESET and clear the counter.
- SW_RESET: count SW_RST_CYCLES cycles, then go to REL_PERIPH and clear the counter.
  - SOFT_RST_REQ is ignored outside RUN.
  - If the request is still high when RUN is re-entered, a new SW_RESET begins.
- Lock loss (lock_s=0) in REL_FAB, REL_PERIPH, RUN or SW_RESET:
  - Next edge: state=WAIT_LOCK, all resets asserted, READY=0.
  - LOCK_LOSS_CNT increments and saturates at 2^CNT_W-1.
  - Lock loss has priority over SOFT_RST_REQ and over any counter terminal condition on the same cycle.
- LOCK glitch shorter than one PCLK cycle: it may or may not be captured. If captured, it is treated as a full loss.
- PRESETN asserted mid-sequence: everything returns to reset values immediately (asynchronously). LOCK_LOSS_CNT is cleared.
- The internal counter is wide enough for max(LOCK_STABLE_CYCLES, STAGE_DELAY, SW_RST_CYCLES) and never wraps.

Test Plan:
- Timing reference for all scenarios: edge n is the first PCLK edge at which synchronizer flop 1 captures LOCK=1. Defaults are used unless stated.
- Power-up: PRESETN low for 5 cycles with LOCK=0 -> all outputs 0, STATE=0 throughout.
- Normal lock: LOCK rises and stays high.
  - FAB_RESET_N=1 after edge n+18.
  - PERIPH_RESET_N=1 after edge n+22.
  - READY=1 after edge n+26.
  - LOCK_LOSS_CNT=0.
- Unstable lock: LOCK high for 10 cycles, low for 3, then high.
  - No release during the first pulse; STATE returns to 0; LOCK_LOSS_CNT stays 0.
  - Full sequence completes relative to the second rise.
- Lock loss in RUN: drop LOCK.
  - Within 3 edges all outputs are 0 and LOCK_LOSS_CNT=1.
  - Repeating 20 times with CNT_W=4 -> LOCK_LOSS_CNT saturates at 15.
- Soft reset: 1-cycle SOFT_RST_REQ pulse in RUN.
  - PERIPH_RESET_N=0 and READY=0 for 8 cycles; FAB_RESET_N stays 1.
  - Then PERIPH_RESET_N=1, and 4 cycles later READY=1.
- Simultaneous events: SOFT_RST_REQ=1 on the same cycle lock_s falls -> STATE=0 and LOCK_LOSS_CNT increments. Separately, PRESETN pulsed low during REL_PERIPH -> immediate return to reset values, then a full resequence.
